// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/
// writeback over the shared-memory datapath, with memory-ready waits.
//
// Ports:
//   clk, rst       rising-edge clock, async active-high reset
//   Op             opcode from IR
//   Zero           ALU zero flag (beq)
//   MemRdy         memory completes this cycle
//   PCWrt, AdrSrc, MemWrt, IRWrt, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUOp, RegWrt  datapath controls
//   ImmSrc         immediate format (combinational on Op)
//   Illegal        sticky unsupported-opcode flag (HALT state)
//   Retired        wrapping count of completed instructions
module multicycle_main_fsm #(
    parameter int WAIT_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op,
    input  logic             Zero,
    input  logic             MemRdy,
    output logic             PCWrt,
    output logic             AdrSrc,
    output logic             MemWrt,
    output logic             IRWrt,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrt,
    output logic [1:0]       ImmSrc,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       pc_upd;
        logic       branch;
        logic       adr_src;
        logic       mem_wrt;
        logic       reg_wrt;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore decode of a state's control word
    function automatic ctrl_t f_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.src_b      = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.src_a = 2'b01;
                c.src_b = 2'b01;
            end
            S_MEMADR: begin
                c.src_a = 2'b10;
                c.src_b = 2'b01;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_wrt    = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src = 1'b1;
                c.mem_wrt = 1'b1;
            end
            S_EXECR: begin
                c.src_a  = 2'b10;
                c.alu_op = 2'b10;
            end
            S_EXECI: begin
                c.src_a  = 2'b10;
                c.src_b  = 2'b01;
                c.alu_op = 2'b10;
            end
            S_ALUWB:    c.reg_wrt = 1'b1;
            S_BEQ: begin
                c.src_a  = 2'b10;
                c.alu_op = 2'b01;
                c.branch = 1'b1;
            end
            S_JAL: begin
                c.src_a  = 2'b01;
                c.src_b  = 2'b10;
                c.pc_upd = 1'b1;
            end
            S_HALT:     c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t           r_state;
    ctrl_t            r_c;
    logic [CNT_W-1:0] r_retired;
    state_t           w_next;
    logic             w_rdy;
    logic             w_retire;

    assign w_rdy = (WAIT_EN == 0) ? 1'b1 : MemRdy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_rdy) w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR:
                w_next = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_rdy) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (w_rdy) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    // An instruction retires on its final state's exit to FETCH
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state == S_MEMWB || r_state == S_MEMWRITE ||
                       r_state == S_ALUWB || r_state == S_BEQ);

    // Control word is registered from the next state so outputs are
    // glitch-free flops that match r_state every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_c       <= f_ctrl(S_FETCH);
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_c     <= f_ctrl(w_next);
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Handshake- and flag-dependent enables stay combinational;
    // rst masks them since the FETCH word is loaded during reset
    assign IRWrt  = ~rst & r_c.fetch & w_rdy;
    assign PCWrt  = ~rst & ((r_c.fetch & w_rdy) | r_c.pc_upd |
                            (r_c.branch & Zero));
    assign MemWrt = ~rst & r_c.mem_wrt;
    assign RegWrt = ~rst & r_c.reg_wrt;

    assign AdrSrc    = r_c.adr_src;
    assign ResultSrc = r_c.result_src;
    assign ALUSrcA   = r_c.src_a;
    assign ALUSrcB   = r_c.src_b;
    assign ALUOp     = r_c.alu_op;
    assign Illegal   = r_c.illegal;
    assign Retired   = r_retired;

    always_comb begin
        ImmSrc = 2'b00;
        case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: per-state control words,
// wait states, halt, retired counter wrap, WAIT_EN=0 instance.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic       Zero;
    logic       MemRdy;

    logic       PCWrt, AdrSrc, MemWrt, IRWrt, RegWrt, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [1:0] Retired;

    logic        nPCWrt, nAdrSrc, nMemWrt, nIRWrt, nRegWrt, nIllegal;
    logic [1:0]  nResultSrc, nALUSrcA, nALUSrcB, nALUOp, nImmSrc;
    logic [15:0] nRetired;

    int n_chk  = 0;
    int n_fail = 0;
    logic [1:0] exp_ret;

    always #5 clk = ~clk;

    multicycle_main_fsm #(.WAIT_EN(1), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .MemRdy(MemRdy),
        .PCWrt(PCWrt), .AdrSrc(AdrSrc), .MemWrt(MemWrt), .IRWrt(IRWrt),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .RegWrt(RegWrt), .ImmSrc(ImmSrc),
        .Illegal(Illegal), .Retired(Retired)
    );

    multicycle_main_fsm #(.WAIT_EN(0), .CNT_W(16)) u_nw (
        .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .MemRdy(MemRdy),
        .PCWrt(nPCWrt), .AdrSrc(nAdrSrc), .MemWrt(nMemWrt),
        .IRWrt(nIRWrt), .ResultSrc(nResultSrc), .ALUSrcA(nALUSrcA),
        .ALUSrcB(nALUSrcB), .ALUOp(nALUOp), .RegWrt(nRegWrt),
        .ImmSrc(nImmSrc), .Illegal(nIllegal), .Retired(nRetired)
    );

    logic [13:0] sig, nsig;
    assign sig  = {PCWrt, AdrSrc, MemWrt, IRWrt, ResultSrc, ALUSrcA,
                   ALUSrcB, ALUOp, RegWrt, Illegal};
    assign nsig = {nPCWrt, nAdrSrc, nMemWrt, nIRWrt, nResultSrc,
                   nALUSrcA, nALUSrcB, nALUOp, nRegWrt, nIllegal};

    // {PCWrt,AdrSrc,MemWrt,IRWrt,RS,SrcA,SrcB,ALUOp,RegWrt,Illegal}
    localparam logic [13:0] E_FET  = 14'b1001_10_00_10_00_0_0;
    localparam logic [13:0] E_FWT  = 14'b0000_10_00_10_00_0_0;
    localparam logic [13:0] E_DEC  = 14'b0000_00_01_01_00_0_0;
    localparam logic [13:0] E_MADR = 14'b0000_00_10_01_00_0_0;
    localparam logic [13:0] E_MRD  = 14'b0100_00_00_00_00_0_0;
    localparam logic [13:0] E_MWB  = 14'b0000_01_00_00_00_1_0;
    localparam logic [13:0] E_MWR  = 14'b0110_00_00_00_00_0_0;
    localparam logic [13:0] E_EXR  = 14'b0000_00_10_00_10_0_0;
    localparam logic [13:0] E_EXI  = 14'b0000_00_10_01_10_0_0;
    localparam logic [13:0] E_AWB  = 14'b0000_00_00_00_00_1_0;
    localparam logic [13:0] E_BEQZ = 14'b1000_00_10_00_01_0_0;
    localparam logic [13:0] E_BEQN = 14'b0000_00_10_00_01_0_0;
    localparam logic [13:0] E_JAL  = 14'b1000_00_01_10_00_0_0;
    localparam logic [13:0] E_HLT  = 14'b0000_00_00_00_00_0_1;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1110011;

    task automatic test_reset();
        rst = 1'b1; Op = OP_R; Zero = 1'b0; MemRdy = 1'b1;
        #1;
        n_chk++;
        if (sig !== E_FWT) begin
            n_fail++;
            $display("FAIL reset_sig got=%b exp=%b", sig, E_FWT);
        end
        n_chk++;
        if (Retired !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ret got=%0d exp=0", Retired);
        end
        @(posedge clk); #1;
        rst = 1'b0; MemRdy = 1'b0;
        exp_ret = 2'd0;
    endtask

    task automatic test_immsrc();
        logic [6:0] ops[7];
        logic [1:0] ex[7];
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_BAD};
        ex  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 7; i++) begin
            Op = ops[i];
            #1;
            n_chk++;
            if (ImmSrc !== ex[i]) begin
                n_fail++;
                $display("FAIL immsrc op=%b got=%b exp=%b",
                         ops[i], ImmSrc, ex[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [13:0] e[4];
        e = '{E_FET, E_DEC, E_EXR, E_AWB};
        Op = OP_R; MemRdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if (sig !== e[i] || Retired !== exp_ret) begin
                n_fail++;
                $display("FAIL rtype cyc%0d got=%b/%0d exp=%b/%0d",
                         i, sig, Retired, e[i], exp_ret);
            end
            @(posedge clk); #1;
        end
        exp_ret++;
        n_chk++;
        if (Retired !== exp_ret) begin
            n_fail++;
            $display("FAIL rtype_ret got=%0d exp=%0d", Retired, exp_ret);
        end
    endtask

    task automatic test_lw_wait();
        logic [13:0] e[8];
        logic        r[8];
        int          irw;
        e = '{E_FWT, E_FWT, E_FET, E_DEC, E_MADR, E_MRD, E_MRD, E_MWB};
        r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        Op = OP_LW; irw = 0;
        for (int i = 0; i < 8; i++) begin
            MemRdy = r[i];
            #1;
            if (IRWrt === 1'b1) irw++;
            n_chk++;
            if (sig !== e[i]) begin
                n_fail++;
                $display("FAIL lw cyc%0d got=%b exp=%b", i, sig, e[i]);
            end
            @(posedge clk); #1;
        end
        exp_ret++;
        MemRdy = 1'b1;
        #1;
        n_chk++;
        if (sig !== E_FET || Retired !== exp_ret || irw != 1) begin
            n_fail++;
            $display("FAIL lw_end got=%b/%0d/%0d exp=%b/%0d/1",
                     sig, Retired, irw, E_FET, exp_ret);
        end
    endtask

    task automatic test_sw_wait();
        logic [13:0] e[6];
        logic        r[6];
        e = '{E_FET, E_DEC, E_MADR, E_MWR, E_MWR, E_MWR};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        Op = OP_SW;
        for (int i = 0; i < 6; i++) begin
            MemRdy = r[i];
            #1;
            n_chk++;
            if (sig !== e[i]) begin
                n_fail++;
                $display("FAIL sw cyc%0d got=%b exp=%b", i, sig, e[i]);
            end
            @(posedge clk); #1;
        end
        MemRdy = 1'b1;
        #1;
        n_chk++;
        if (sig !== E_MWR || Retired !== exp_ret) begin
            n_fail++;
            $display("FAIL sw_last got=%b/%0d exp=%b/%0d",
                     sig, Retired, E_MWR, exp_ret);
        end
        @(posedge clk); #1;
        exp_ret++;
        n_chk++;
        if (sig !== E_FET || Retired !== exp_ret) begin
            n_fail++;
            $display("FAIL sw_end got=%b/%0d exp=%b/%0d",
                     sig, Retired, E_FET, exp_ret);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [13:0] e[3];
        e = '{E_FET, E_DEC, z ? E_BEQZ : E_BEQN};
        Op = OP_BEQ; MemRdy = 1'b1; Zero = z;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (sig !== e[i]) begin
                n_fail++;
                $display("FAIL beq z=%0b cyc%0d got=%b exp=%b",
                         z, i, sig, e[i]);
            end
            @(posedge clk); #1;
        end
        Zero = 1'b0;
        exp_ret++;
        n_chk++;
        if (Retired !== exp_ret) begin
            n_fail++;
            $display("FAIL beq_ret got=%0d exp=%0d", Retired, exp_ret);
        end
    endtask

    task automatic test_jal_itype();
        logic [13:0] e[8];
        logic [6:0]  o[8];
        e = '{E_FET, E_DEC, E_JAL, E_AWB, E_FET, E_DEC, E_EXI, E_AWB};
        o = '{OP_JAL, OP_JAL, OP_JAL, OP_JAL, OP_I, OP_I, OP_I, OP_I};
        MemRdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Op = o[i];
            #1;
            n_chk++;
            if (sig !== e[i]) begin
                n_fail++;
                $display("FAIL jal_i cyc%0d got=%b exp=%b", i, sig, e[i]);
            end
            @(posedge clk); #1;
        end
        exp_ret += 2'd2;
        n_chk++;
        if (Retired !== exp_ret) begin
            n_fail++;
            $display("FAIL jal_i_ret got=%0d exp=%0d", Retired, exp_ret);
        end
    endtask

    task automatic test_halt();
        Op = OP_BAD; MemRdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 22; i++) begin
            MemRdy = 1'($urandom_range(1));
            Zero   = 1'($urandom_range(1));
            #1;
            n_chk++;
            if (sig !== E_HLT || Retired !== exp_ret) begin
                n_fail++;
                $display("FAIL halt cyc%0d got=%b/%0d exp=%b/%0d",
                         i, sig, Retired, E_HLT, exp_ret);
            end
            @(posedge clk); #1;
        end
        Zero = 1'b0; MemRdy = 1'b1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (sig !== E_FWT || Retired !== 2'd0) begin
            n_fail++;
            $display("FAIL halt_rst got=%b/%0d exp=%b/0",
                     sig, Retired, E_FWT);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 2'd0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] er[5];
        er = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        Op = OP_R; MemRdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(posedge clk);
            #1;
            n_chk++;
            if (sig !== E_FET || Retired !== er[k]) begin
                n_fail++;
                $display("FAIL b2b k=%0d got=%b/%0d exp=%b/%0d",
                         k, sig, Retired, E_FET, er[k]);
            end
        end
    endtask

    task automatic test_reset_memread();
        Op = OP_LW; MemRdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        MemRdy = 1'b0;
        #1;
        n_chk++;
        if (sig !== E_MRD || Retired !== 2'd1) begin
            n_fail++;
            $display("FAIL mrd_pre got=%b/%0d exp=%b/1",
                     sig, Retired, E_MRD);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (sig !== E_FWT || Retired !== 2'd0) begin
            n_fail++;
            $display("FAIL mrd_rst got=%b/%0d exp=%b/0",
                     sig, Retired, E_FWT);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_no_wait();
        logic [13:0] e[5];
        e = '{E_FET, E_DEC, E_MADR, E_MRD, E_MWB};
        Op = OP_LW; MemRdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++;
            if (nsig !== e[i]) begin
                n_fail++;
                $display("FAIL nowait cyc%0d got=%b exp=%b",
                         i, nsig, e[i]);
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (nsig !== E_FET || nRetired !== 16'd1 || sig !== E_FWT) begin
            n_fail++;
            $display("FAIL nowait_end got=%b/%0d/%b exp=%b/1/%b",
                     nsig, nRetired, sig, E_FET, E_FWT);
        end
    endtask

    initial begin
        test_reset();
        test_immsrc();
        test_rtype();
        test_lw_wait();
        test_sw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal_itype();
        test_halt();
        test_back_to_back();
        test_reset_memread();
        test_no_wait();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
